// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam int PORT0    = 0;
    localparam int PORT1    = 1;
    localparam int WORD_LSB = 2;

endpackage

// File: rtl/dmem_arb_resp.sv
// Per-port response register: captures read data or an out-of-range error
// on the transfer edge and presents it with a one-cycle valid pulse.
module dmem_arb_resp (
    input  logic        clk,
    input  logic        reset,
    input  logic        transfer,
    input  logic        oob,
    input  logic        we,
    input  logic [31:0] mem_data,
    output logic        rvalid,
    output logic        err,
    output logic [31:0] rdata
);

    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid <= 1'b0;
            err    <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= transfer & (oob | ~we);
            err    <= transfer & oob;
            // rdata is only replaced when a response is produced, so it holds otherwise
            if (transfer && oob) begin
                rdata <= '0;
            end else if (transfer && !we) begin
                rdata <= mem_data;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the core
// (port 0) and the accelerator/loader (port 1), with bounded locked bursts.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MAX_BURST = 8,
    parameter int ADDR_BITS = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        lock0,
    input  logic        lock1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        err0,
    output logic        err1,
    output logic        MemWrite,
    output logic        MemRead,
    output logic [31:0] read_address,
    output logic [31:0] Write_data,
    input  logic [31:0] MemData_out,
    output logic [1:0]  dbg_state
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [31:0] WORD_MASK = ~32'((1 << WORD_LSB) - 1);

    arb_state_t       state, state_next;
    logic             last_owner, last_next;
    logic [CNT_W-1:0] beat_cnt, beat_next;

    logic        owned, own_sel;
    logic        own_req, own_lock, own_we, own_oob, other_req, transfer;
    logic [31:0] own_addr, own_wdata;
    logic        oob0, oob1;

    assign oob0 = |addr0[31:ADDR_BITS];
    assign oob1 = |addr1[31:ADDR_BITS];

    assign owned     = (state != IDLE);
    assign own_sel   = (state == OWN1) ? 1'(PORT1) : 1'(PORT0);
    assign own_req   = own_sel ? req1   : req0;
    assign own_lock  = own_sel ? lock1  : lock0;
    assign own_we    = own_sel ? we1    : we0;
    assign own_oob   = own_sel ? oob1   : oob0;
    assign own_addr  = own_sel ? addr1  : addr0;
    assign own_wdata = own_sel ? wdata1 : wdata0;
    assign other_req = own_sel ? req0   : req1;

    assign transfer = owned & own_req;
    assign gnt0     = transfer & ~own_sel;
    assign gnt1     = transfer & own_sel;

    // Out-of-range transfers still complete, but never touch the memory
    assign MemRead      = transfer & ~own_we & ~own_oob;
    assign MemWrite     = transfer & own_we & ~own_oob;
    assign read_address = owned ? (own_addr & WORD_MASK) : '0;
    assign Write_data   = owned ? own_wdata : '0;

    assign dbg_state = state;

    always_comb begin
        state_next = state;
        last_next  = last_owner;
        beat_next  = beat_cnt;
        if (!owned) begin
            if (req0 && req1) begin
                state_next = (last_owner == 1'(PORT1)) ? OWN0 : OWN1;
            end else if (req0) begin
                state_next = OWN0;
            end else if (req1) begin
                state_next = OWN1;
            end
        end else if (transfer && own_lock && (beat_cnt < BEAT_LAST)) begin
            beat_next = beat_cnt + CNT_W'(1);
        end else if (!own_req && own_lock) begin
            beat_next = beat_cnt;
        end else begin
            // Release: the other port takes over directly if it is waiting
            last_next = own_sel;
            beat_next = '0;
            if (other_req) begin
                state_next = own_sel ? OWN0 : OWN1;
            end else begin
                state_next = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_owner <= 1'(PORT1);
            beat_cnt   <= '0;
        end else begin
            state      <= state_next;
            last_owner <= last_next;
            beat_cnt   <= beat_next;
        end
    end

    dmem_arb_resp u_resp0 (
        .clk      (clk),
        .reset    (reset),
        .transfer (gnt0),
        .oob      (oob0),
        .we       (we0),
        .mem_data (MemData_out),
        .rvalid   (rvalid0),
        .err      (err0),
        .rdata    (rdata0)
    );

    dmem_arb_resp u_resp1 (
        .clk      (clk),
        .reset    (reset),
        .transfer (gnt1),
        .oob      (oob1),
        .we       (we1),
        .mem_data (MemData_out),
        .rvalid   (rvalid1),
        .err      (err1),
        .rdata    (rdata1)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: queue-fed drivers, an ownership-level reference model
// that predicts grants and memory drive, and a response scoreboard.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int MAX_BURST = 8;
    localparam int ADDR_BITS = 12;

    logic        clk, reset;
    logic        req0, req1, lock0, lock1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic        MemWrite, MemRead;
    logic [31:0] read_address, Write_data, MemData_out;
    logic [1:0]  dbg_state;

    dmem_arbiter #(.MAX_BURST(MAX_BURST), .ADDR_BITS(ADDR_BITS)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
        .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
        .MemWrite(MemWrite), .MemRead(MemRead),
        .read_address(read_address), .Write_data(Write_data),
        .MemData_out(MemData_out), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset / memory device ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];
    assign MemData_out = mem[read_address[11:2]];
    always @(posedge clk) if (MemWrite) mem[read_address[11:2]] <= Write_data;

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int failures = 0;
    bit check_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- drivers ----------------
    // transaction = {lock, we, addr, wdata}
    logic [65:0] txq [2][$];
    logic [48:0] exp_q [2][$];   // {due_cycle[15:0], err, rdata}
    bit took [2];
    bit idle_lock [2];

    initial begin
        req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        forever begin
            @(posedge clk);
            #1;
            for (int p = 0; p < 2; p++) begin
                if (took[p] && txq[p].size() > 0) txq[p].delete(0);
                took[p] = 0;
            end
            if (txq[0].size() > 0) begin
                {lock0, we0, addr0, wdata0} = txq[0][0];
                req0 = 1;
            end else begin
                req0 = 0; lock0 = idle_lock[0];
            end
            if (txq[1].size() > 0) begin
                {lock1, we1, addr1, wdata1} = txq[1][0];
                req1 = 1;
            end else begin
                req1 = 0; lock1 = idle_lock[1];
            end
        end
    end

    task automatic push_tx(input int p, input bit lk, input bit w, input logic [31:0] a,
                           input logic [31:0] d);
        txq[p].push_back({lk, w, a, d});
    endtask

    // ---------------- reference model ----------------
    // owner: -1 nobody, 0/1 port; beats = locked transfers in the current tenure
    int owner = -1;
    int last  = 1;
    int beats = 0;

    task automatic model_step();
        bit r [2];
        bit l [2];
        bit w [2];
        logic [31:0] a [2];
        logic [31:0] d [2];
        bit xfer, oob;
        int x;
        r[0] = req0;  r[1] = req1;  l[0] = lock0; l[1] = lock1;
        w[0] = we0;   w[1] = we1;   a[0] = addr0; a[1] = addr1;
        d[0] = wdata0; d[1] = wdata1;
        x = owner;
        xfer = (x >= 0) && r[x];
        check("gnt0", 32'(gnt0), 32'(xfer && x == 0));
        check("gnt1", 32'(gnt1), 32'(xfer && x == 1));
        if (xfer) begin
            oob = (a[x] >> ADDR_BITS) != 0;
            check("mem_read", 32'(MemRead), 32'(!w[x] && !oob));
            check("mem_write", 32'(MemWrite), 32'(w[x] && !oob));
            check("read_address", read_address, a[x]);
            if (w[x]) check("write_data", Write_data, d[x]);
            if (w[x] && !oob) ref_mem[a[x][11:2]] = d[x];
            if (!reset && (oob || !w[x]))
                exp_q[x].push_back({16'(cyc + 1), oob, oob ? 32'h0 : ref_mem[a[x][11:2]]});
        end else begin
            check("mem_idle_rd", 32'(MemRead), 32'h0);
            check("mem_idle_wr", 32'(MemWrite), 32'h0);
            if (x < 0) check("addr_idle", read_address, 32'h0);
        end
        if (reset) begin
            owner = -1; last = 1; beats = 0;
        end else if (x < 0) begin
            if (r[0] && r[1]) owner = 1 - last;
            else if (r[0]) owner = 0;
            else if (r[1]) owner = 1;
        end else if (xfer && l[x] && beats + 1 < MAX_BURST) begin
            beats++;
        end else if (!r[x] && l[x]) begin
            // owner holds the memory without transferring
        end else begin
            last = x; beats = 0;
            owner = r[1 - x] ? 1 - x : -1;
        end
    endtask

    always @(negedge clk) begin
        took[0] = gnt0;
        took[1] = gnt1;
        if (check_en) model_step();
    end

    // ---------------- response monitor ----------------
    task automatic mon_port(input int p, input bit rv, input bit er, input logic [31:0] rd);
        logic [48:0] e;
        if (rv) begin
            checks++;
            if (exp_q[p].size() == 0) begin
                failures++;
                $display("FAIL rvalid%0d_unexpected: got rvalid=1 expected none (cycle %0d)", p, cyc);
            end else begin
                e = exp_q[p].pop_front();
                check($sformatf("rvalid%0d_cycle", p), 32'(cyc), 32'(e[48:33]));
                check($sformatf("err%0d", p), 32'(er), 32'(e[32]));
                check($sformatf("rdata%0d", p), rd, e[31:0]);
            end
        end else begin
            check($sformatf("err%0d_idle", p), 32'(er), 32'h0);
            if (exp_q[p].size() > 0 && 32'(exp_q[p][0][48:33]) <= 32'(cyc)) begin
                e = exp_q[p].pop_front();
                check($sformatf("rvalid%0d_missing", p), 32'(rv), 32'h1);
            end
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            mon_port(0, rvalid0, err0, rdata0);
            mon_port(1, rvalid1, err1, rdata1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_drain(input int max_cycles);
        bit done;
        done = 0;
        for (int i = 0; i < max_cycles; i++) begin
            @(posedge clk);
            #3;
            if (txq[0].size() == 0 && txq[1].size() == 0 && !req0 && !req1 &&
                exp_q[0].size() == 0 && exp_q[1].size() == 0) begin
                done = 1;
                break;
            end
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL drain_timeout: got pending work expected drained within %0d cycles",
                     max_cycles);
            txq[0].delete(); txq[1].delete();
        end
        @(posedge clk);
        #2;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[0] = 32'hA5A5_0000;  ref_mem[0] = 32'hA5A5_0000;
        mem[4] = 32'hDEADBEEF;   ref_mem[4] = 32'hDEADBEEF;
        idle_lock[0] = 0; idle_lock[1] = 0;

        reset = 1;
        repeat (3) @(posedge clk);
        #2;
        reset = 0;
        check_en = 1;
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        check("rst_rdata0", rdata0, 32'h0);
        check("rst_rdata1", rdata1, 32'h0);
        check("rst_rvalid", 32'({rvalid1, rvalid0}), 32'h0);
        check("rst_err", 32'({err1, err0}), 32'h0);
        check("rst_mem_ctl", 32'({MemRead, MemWrite}), 32'h0);

        // single read of a known word
        push_tx(0, 0, 0, 32'h10, 32'h0);
        wait_drain(20);
        check("dir_rdata0_beef", rdata0, 32'hDEADBEEF);

        // simultaneous requests from IDLE, twice
        for (int k = 0; k < 2; k++) begin
            push_tx(0, 0, 0, 32'(8 * k + 32'h20), 32'h0);
            push_tx(1, 0, 0, 32'(8 * k + 32'h24), 32'h0);
            wait_drain(20);
        end

        // port 1 locked burst of 12 reads with port 0 waiting
        for (int k = 0; k < 12; k++) push_tx(1, 1, 0, 32'(4 * k + 32'h80), 32'h0);
        repeat (2) @(posedge clk);
        #2;
        push_tx(0, 0, 0, 32'h10, 32'h0);
        wait_drain(60);

        // write by port 0, read back by port 1
        push_tx(0, 0, 1, 32'h40, 32'h12345678);
        wait_drain(20);
        push_tx(1, 0, 0, 32'h40, 32'h0);
        wait_drain(20);
        check("dir_rdata1_wr", rdata1, 32'h12345678);

        // out-of-range accesses leave memory untouched
        push_tx(1, 0, 0, 32'h0000_1000, 32'h0);
        push_tx(1, 0, 1, 32'h0000_1000, 32'hFFFF_FFFF);
        wait_drain(20);
        check("dir_oob_mem", mem[0], 32'hA5A5_0000);
        check("dir_oob_rdata1", rdata1, 32'h0);

        // reset in the middle of a locked port-0 burst, port 1 waiting
        for (int k = 0; k < 6; k++) push_tx(0, 1, k[0], 32'(4 * k + 32'h100), $urandom);
        repeat (3) @(posedge clk);
        #2;
        push_tx(1, 0, 0, 32'h44, 32'h0);
        @(posedge clk);
        #2;
        reset = 1;
        txq[0].delete();
        req0 = 0; lock0 = 0;
        @(posedge clk);
        #2;
        reset = 0;
        check("midrst_state", 32'(dbg_state), 32'(IDLE));
        check("midrst_gnt", 32'({gnt1, gnt0}), 32'h0);
        check("midrst_rvalid", 32'({rvalid1, rvalid0}), 32'h0);
        @(posedge clk);
        #2;
        check("midrst_gnt1", 32'(gnt1), 32'h1);
        wait_drain(20);

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            for (int p = 0; p < 2; p++) begin
                idle_lock[p] = ($urandom_range(0, 15) == 0);
                if (txq[p].size() == 0 && $urandom_range(0, 99) < 55) begin
                    int n;
                    bit lk;
                    n = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 11) : 1;
                    for (int k = 0; k < n; k++) begin
                        logic [31:0] a;
                        a = {22'h0, 5'($urandom_range(0, 31)), 2'b00} + 32'h200;
                        if ($urandom_range(0, 15) == 0) a = {$urandom_range(1, 255), 12'h0} | a;
                        lk = ($urandom_range(0, 2) != 0) && (n > 1);
                        push_tx(p, lk, 1'($urandom_range(0, 1)), a, $urandom);
                    end
                end
            end
            @(posedge clk);
            #2;
        end
        idle_lock[0] = 0; idle_lock[1] = 0;
        wait_drain(400);

        checks++;
        if (exp_q[0].size() != 0 || exp_q[1].size() != 0) begin
            failures++;
            $display("FAIL leftover_resp: got %0d/%0d pending expected 0/0",
                     exp_q[0].size(), exp_q[1].size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
